// File: rtl/l2_line_fill_responder.sv
// L2-side line-fill responder: takes one I-cache line-miss request, fetches the line as a
// burst of memory beats, assembles it and returns it with a one-cycle valid pulse.
module l2_line_fill_responder #(
  parameter int unsigned data_width    = 32,
  parameter int unsigned address_width = 32,
  parameter int unsigned block_size    = 32,
  parameter int unsigned mem_width     = 64
) (
  input  logic                                                         CLK,
  input  logic                                                         RST,
  input  logic                                                         ADDR_FROM_L1_VALID,
  input  logic [address_width-$clog2(block_size*data_width/8)-1:0]     ADDR_FROM_L1,
  output logic [block_size*data_width-1:0]                             DATA_TO_L1,
  output logic                                                         DATA_TO_L1_VALID,
  output logic                                                         BUSY,
  output logic                                                         REQ_DROPPED,
  output logic [address_width-1:0]                                     MEM_ADDR,
  output logic                                                         MEM_ADDR_VALID,
  input  logic                                                         MEM_ADDR_READY,
  input  logic [mem_width-1:0]                                         MEM_DATA,
  input  logic                                                         MEM_DATA_VALID
);

  localparam int unsigned cache_width  = block_size * data_width;
  localparam int unsigned offset_width = $clog2(cache_width / 8);
  localparam int unsigned line_width   = address_width - offset_width;
  localparam int unsigned beats        = cache_width / mem_width;
  localparam int unsigned cnt_width    = (beats > 1) ? $clog2(beats) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_e;

  state_e                   state_q, state_d;
  logic [line_width-1:0]    line_q, line_d;
  logic [cnt_width-1:0]     cnt_q, cnt_d;
  logic [cache_width-1:0]   line_buf_q, line_buf_d;
  logic                     data_valid_q, data_valid_d;
  logic                     busy_q, busy_d;
  logic                     addr_valid_q, addr_valid_d;
  logic                     req_dropped_q, req_dropped_d;

  // Next-state, beat assembly and registered-output decode
  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    cnt_d         = cnt_q;
    line_buf_d    = line_buf_q;
    req_dropped_d = ADDR_FROM_L1_VALID && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (ADDR_FROM_L1_VALID) begin
          line_d  = ADDR_FROM_L1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (MEM_ADDR_READY) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // Beat 0 carries the lowest addresses, i.e. the line LSBs
        if (MEM_DATA_VALID) begin
          line_buf_d[int'(cnt_q)*int'(mem_width) +: mem_width] = MEM_DATA;
          cnt_d = cnt_q + cnt_width'(1);
          if (cnt_q == cnt_width'(beats - 1)) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d       = (state_d != ST_IDLE);
    addr_valid_d = (state_d == ST_ADDR);
    data_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      line_q        <= '0;
      cnt_q         <= '0;
      line_buf_q    <= '0;
      data_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      addr_valid_q  <= 1'b0;
      req_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      cnt_q         <= cnt_d;
      line_buf_q    <= line_buf_d;
      data_valid_q  <= data_valid_d;
      busy_q        <= busy_d;
      addr_valid_q  <= addr_valid_d;
      req_dropped_q <= req_dropped_d;
    end
  end

  assign DATA_TO_L1       = line_buf_q;
  assign DATA_TO_L1_VALID = data_valid_q;
  assign BUSY             = busy_q;
  assign REQ_DROPPED      = req_dropped_q;
  assign MEM_ADDR         = {line_q, offset_width'(0)};
  assign MEM_ADDR_VALID   = addr_valid_q;

endmodule

// File: tb/tb_l2_line_fill_responder.sv
// Directed bench for l2_line_fill_responder at default parameters (1024-bit line, 16 x 64-bit beats).
module tb_l2_line_fill_responder;

  localparam int unsigned LW = 25;
  localparam int unsigned CW = 1024;
  localparam int unsigned NB = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          ADDR_FROM_L1_VALID;
  logic [LW-1:0] ADDR_FROM_L1;
  logic [CW-1:0] DATA_TO_L1;
  logic          DATA_TO_L1_VALID;
  logic          BUSY;
  logic          REQ_DROPPED;
  logic [31:0]   MEM_ADDR;
  logic          MEM_ADDR_VALID;
  logic          MEM_ADDR_READY;
  logic [63:0]   MEM_DATA;
  logic          MEM_DATA_VALID;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  int p0;
  logic [63:0] exp_beats [NB];

  l2_line_fill_responder dut (
    .CLK               (CLK),
    .RST               (RST),
    .ADDR_FROM_L1_VALID(ADDR_FROM_L1_VALID),
    .ADDR_FROM_L1      (ADDR_FROM_L1),
    .DATA_TO_L1        (DATA_TO_L1),
    .DATA_TO_L1_VALID  (DATA_TO_L1_VALID),
    .BUSY              (BUSY),
    .REQ_DROPPED       (REQ_DROPPED),
    .MEM_ADDR          (MEM_ADDR),
    .MEM_ADDR_VALID    (MEM_ADDR_VALID),
    .MEM_ADDR_READY    (MEM_ADDR_READY),
    .MEM_DATA          (MEM_DATA),
    .MEM_DATA_VALID    (MEM_DATA_VALID)
  );

  always #5 CLK = ~CLK;

  // Count valid pulses seen mid-cycle
  always @(negedge CLK) begin
    if (DATA_TO_L1_VALID === 1'b1) pulses++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag);
    for (int k = 0; k < int'(NB); k++) begin
      chk($sformatf("%s[%0d]", tag, k), DATA_TO_L1[k*64 +: 64], exp_beats[k]);
    end
  endtask

  task automatic run_beats();
    for (int k = 0; k < int'(NB); k++) begin
      MEM_DATA       = exp_beats[k];
      MEM_DATA_VALID = 1'b1;
      tick();
    end
    MEM_DATA_VALID = 1'b0;
  endtask

  task automatic request(input logic [LW-1:0] line);
    ADDR_FROM_L1       = line;
    ADDR_FROM_L1_VALID = 1'b1;
    tick();
    ADDR_FROM_L1_VALID = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    ADDR_FROM_L1_VALID = 1'b0;
    ADDR_FROM_L1 = '0;
    MEM_ADDR_READY = 1'b0;
    MEM_DATA = '0;
    MEM_DATA_VALID = 1'b0;

    // Reset state
    tick(); tick();
    RST = 1'b0;
    tick();
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_valid", 64'(DATA_TO_L1_VALID), 64'd0);
    chk("rst_addr_valid", 64'(MEM_ADDR_VALID), 64'd0);
    chk("rst_addr", 64'(MEM_ADDR), 64'd0);
    chk("rst_dropped", 64'(REQ_DROPPED), 64'd0);
    for (int k = 0; k < int'(NB); k++) exp_beats[k] = 64'd0;
    chk_line("rst_line");

    // Single fill, ready high: valid expected at cycle 18
    for (int k = 0; k < int'(NB); k++) exp_beats[k] = {16{4'(k)}};
    MEM_ADDR_READY = 1'b1;
    p0 = pulses;
    request(25'h0123456);
    chk("t1_addr_valid", 64'(MEM_ADDR_VALID), 64'd1);
    chk("t1_addr", 64'(MEM_ADDR), 64'h091A2B00);
    chk("t1_busy", 64'(BUSY), 64'd1);
    tick();
    chk("t1_addr_valid_c2", 64'(MEM_ADDR_VALID), 64'd0);
    run_beats();
    chk("t1_valid_c18", 64'(DATA_TO_L1_VALID), 64'd1);
    chk_line("t1_line");
    tick();
    chk("t1_valid_c19", 64'(DATA_TO_L1_VALID), 64'd0);
    chk("t1_busy_c19", 64'(BUSY), 64'd0);
    chk("t1_pulses", 64'(pulses - p0), 64'd1);
    chk_line("t1_line_hold");

    // Address stall: ready low for cycles 1..5; stray beats during ADDR must be ignored
    for (int k = 0; k < int'(NB); k++) exp_beats[k] = ~{16{4'(k)}};
    MEM_ADDR_READY = 1'b0;
    request(25'h1ABCDEF);
    MEM_DATA = 64'hBAD0_BAD0_BAD0_BAD0;
    MEM_DATA_VALID = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("t2_addr_valid_c%0d", c), 64'(MEM_ADDR_VALID), 64'd1);
      chk($sformatf("t2_addr_c%0d", c), 64'(MEM_ADDR), 64'hD5E6F780);
      tick();
    end
    MEM_DATA_VALID = 1'b0;
    MEM_ADDR_READY = 1'b1;
    chk("t2_addr_valid_c6", 64'(MEM_ADDR_VALID), 64'd1);
    tick();
    run_beats();
    chk("t2_valid_c23", 64'(DATA_TO_L1_VALID), 64'd1);
    chk_line("t2_line");
    tick();

    // Gapped beats on alternate cycles
    for (int k = 0; k < int'(NB); k++) exp_beats[k] = {32'(k), 32'hC0DE_0000 + 32'(k)};
    p0 = pulses;
    request(25'h0000001);
    chk("t3_addr", 64'(MEM_ADDR), 64'h0000_0080);
    tick();
    for (int k = 0; k < int'(NB); k++) begin
      MEM_DATA = exp_beats[k];
      MEM_DATA_VALID = 1'b1;
      tick();
      if (k < int'(NB) - 1) begin
        MEM_DATA = 64'hFFFF_FFFF_FFFF_FFFF;
        MEM_DATA_VALID = 1'b0;
        tick();
      end
    end
    MEM_DATA_VALID = 1'b0;
    chk("t3_valid", 64'(DATA_TO_L1_VALID), 64'd1);
    chk_line("t3_line");
    tick();
    chk("t3_pulses", 64'(pulses - p0), 64'd1);

    // Request while busy at cycle 4, then a request in the RESP cycle
    for (int k = 0; k < int'(NB); k++) exp_beats[k] = 64'h0101_0101_0101_0101 * 64'(k + 1);
    p0 = pulses;
    request(25'h0000AAA);
    tick();
    for (int k = 0; k < int'(NB); k++) begin
      MEM_DATA = exp_beats[k];
      MEM_DATA_VALID = 1'b1;
      if (k == 2) begin
        ADDR_FROM_L1 = 25'h1555555;
        ADDR_FROM_L1_VALID = 1'b1;
      end
      tick();
      ADDR_FROM_L1_VALID = 1'b0;
      if (k == 2) begin
        chk("t4_dropped_c5", 64'(REQ_DROPPED), 64'd1);
        chk("t4_addr_c5", 64'(MEM_ADDR), 64'h0005_5500);
      end
      if (k == 3) chk("t4_dropped_c6", 64'(REQ_DROPPED), 64'd0);
    end
    MEM_DATA_VALID = 1'b0;
    chk("t4_valid", 64'(DATA_TO_L1_VALID), 64'd1);
    chk_line("t4_line");
    ADDR_FROM_L1 = 25'h1555555;
    ADDR_FROM_L1_VALID = 1'b1;
    tick();
    ADDR_FROM_L1_VALID = 1'b0;
    chk("t4_dropped_resp", 64'(REQ_DROPPED), 64'd1);
    chk("t4_busy_after", 64'(BUSY), 64'd0);
    chk("t4_addr_after", 64'(MEM_ADDR), 64'h0005_5500);
    chk("t4_pulses", 64'(pulses - p0), 64'd1);

    // Back-to-back: request in the cycle right after the valid pulse
    for (int k = 0; k < int'(NB); k++) exp_beats[k] = {8{8'(8'h30 + 8'(k))}};
    request(25'h0000F0F);
    chk("t5_addr_valid", 64'(MEM_ADDR_VALID), 64'd1);
    chk("t5_addr", 64'(MEM_ADDR), 64'h0007_8780);
    tick();
    run_beats();
    chk("t5_valid", 64'(DATA_TO_L1_VALID), 64'd1);
    chk_line("t5_line");
    tick();

    // Reset at beat 7, stray beats afterwards, then a clean fill
    for (int k = 0; k < int'(NB); k++) exp_beats[k] = 64'hAAAA_0000_0000_0000 + 64'(k);
    p0 = pulses;
    request(25'h0000123);
    tick();
    for (int k = 0; k < 7; k++) begin
      MEM_DATA = exp_beats[k];
      MEM_DATA_VALID = 1'b1;
      tick();
    end
    MEM_DATA = exp_beats[7];
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t6_busy", 64'(BUSY), 64'd0);
    chk("t6_valid", 64'(DATA_TO_L1_VALID), 64'd0);
    chk("t6_addr_valid", 64'(MEM_ADDR_VALID), 64'd0);
    chk("t6_addr", 64'(MEM_ADDR), 64'd0);
    MEM_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int c = 0; c < 4; c++) tick();
    MEM_DATA_VALID = 1'b0;
    for (int k = 0; k < int'(NB); k++) exp_beats[k] = 64'd0;
    chk_line("t6_line_zero");
    chk("t6_busy_stray", 64'(BUSY), 64'd0);
    chk("t6_pulses", 64'(pulses - p0), 64'd0);
    for (int k = 0; k < int'(NB); k++) exp_beats[k] = {16'(k), 16'h5A5A, 16'(k * 7), 16'hA5A5};
    request(25'h0000456);
    chk("t6_new_addr", 64'(MEM_ADDR), 64'h0002_2B00);
    tick();
    run_beats();
    chk("t6_new_valid", 64'(DATA_TO_L1_VALID), 64'd1);
    chk_line("t6_new_line");
    tick();
    chk("t6_new_pulses", 64'(pulses - p0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
